// File: rtl/decada_cnt00_pkg.sv
// decada_pkg: shared digit type, BCD limit and seven-segment patterns
package decada_pkg;
   localparam int DIGIT_W = 4;
   typedef logic [DIGIT_W-1:0] digit_t;
   localparam digit_t BCD_MAX = 4'd9;
   // Patterns are active-low {a,b,c,d,e,f,g}; the top inverts them for common-cathode use
   localparam logic [6:0] SEG_0   = 7'b0000001;
   localparam logic [6:0] SEG_1   = 7'b1001111;
   localparam logic [6:0] SEG_2   = 7'b0010010;
   localparam logic [6:0] SEG_3   = 7'b0000110;
   localparam logic [6:0] SEG_4   = 7'b1001100;
   localparam logic [6:0] SEG_5   = 7'b0100100;
   localparam logic [6:0] SEG_6   = 7'b0100000;
   localparam logic [6:0] SEG_7   = 7'b0001111;
   localparam logic [6:0] SEG_8   = 7'b0000000;
   localparam logic [6:0] SEG_9   = 7'b0000100;
   localparam logic [6:0] SEG_OFF = 7'b1111111;
   // Clamp a loaded digit into the legal BCD range
   function automatic digit_t sat_digit(input digit_t d);
      return (d > BCD_MAX) ? BCD_MAX : d;
   endfunction
endpackage

// File: rtl/decada_cnt00_if.sv
// decada_cnt00_if: control, load and display signals of the decade counter
import decada_pkg::*;
interface decada_cnt00_if;
   logic       en0;
   logic       up0;
   logic       clr0;
   logic       ld0;
   digit_t     din_u;
   digit_t     din_t;
   digit_t     units;
   digit_t     tens;
   logic [6:0] seg_u;
   logic [6:0] seg_t;
   logic       tc;
   logic       wrap0;
   modport master (output en0, up0, clr0, ld0, din_u, din_t,
                   input units, tens, seg_u, seg_t, tc, wrap0);
   modport slave  (input en0, up0, clr0, ld0, din_u, din_t,
                   output units, tens, seg_u, seg_t, tc, wrap0);
endinterface

// File: rtl/decada_cnt00_coder7seg00.sv
// coder7seg00: BCD digit to active-low seven-segment pattern, blank for 10-15
import decada_pkg::*;
module coder7seg00 (
   input  digit_t     bcd_i,
   output logic [6:0] seg_o
);
   // Pure lookup; codes above 9 cannot be held but decode to all-off anyway
   always_comb begin
      case (bcd_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_OFF;
      endcase
   end
endmodule

// File: rtl/decada_cnt00.sv
// decada_cnt00: two-digit BCD up/down counter with clear, load, wrap pulse and 7-seg drive
import decada_pkg::*;
module decada_cnt00 #(
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input logic          clk0,
   input logic          reset0,
   decada_cnt00_if.slave bus
);
   digit_t     units_q, units_d, tens_q, tens_d, up_u, up_t, dn_u, dn_t;
   logic       wrap_q, wrap_d, at_max, at_min;
   logic [6:0] raw_u, raw_t;
   // Per-digit up/down step, terminal count and clr > ld > count > hold selection
   always_comb begin
      at_max  = (units_q == BCD_MAX) && (tens_q == BCD_MAX);
      at_min  = (units_q == '0) && (tens_q == '0);
      up_u    = (units_q == BCD_MAX) ? '0 : units_q + 4'd1;
      up_t    = (units_q != BCD_MAX) ? tens_q : (tens_q == BCD_MAX) ? '0 : tens_q + 4'd1;
      dn_u    = (units_q == '0) ? BCD_MAX : units_q - 4'd1;
      dn_t    = (units_q != '0) ? tens_q : (tens_q == '0) ? BCD_MAX : tens_q - 4'd1;
      bus.tc  = bus.en0 && (bus.up0 ? at_max : at_min);
      units_d = bus.clr0 ? '0 : bus.ld0 ? sat_digit(bus.din_u) : !bus.en0 ? units_q : bus.up0 ? up_u : dn_u;
      tens_d  = bus.clr0 ? '0 : bus.ld0 ? sat_digit(bus.din_t) : !bus.en0 ? tens_q : bus.up0 ? up_t : dn_t;
      wrap_d  = !bus.clr0 && !bus.ld0 && bus.tc;
   end
   // Digit registers and wrap flag, cleared immediately by reset
   always_ff @(posedge clk0 or negedge reset0) begin
      if (!reset0) begin
         units_q <= '0;
         tens_q  <= '0;
         wrap_q  <= 1'b0;
      end else begin
         units_q <= units_d;
         tens_q  <= tens_d;
         wrap_q  <= wrap_d;
      end
   end
   coder7seg00 u_seg_u (.bcd_i(units_q), .seg_o(raw_u));
   coder7seg00 u_seg_t (.bcd_i(tens_q),  .seg_o(raw_t));
   // Drive outputs, inverting segment polarity for common-cathode boards
   always_comb begin
      bus.units = units_q;
      bus.tens  = tens_q;
      bus.wrap0 = wrap_q;
      bus.seg_u = SEG_ACTIVE_LOW ? raw_u : ~raw_u;
      bus.seg_t = SEG_ACTIVE_LOW ? raw_t : ~raw_t;
   end
endmodule
